lisnoc_router_input_route_vc: RTL and testbench

//  Multi-virtual-channel successor of the router input routing stage; sits between per-VC input FIFOs and the switch arbiters.
//  - Per VC: looks up the output direction from the header destination and holds that route for the whole packet.
//  - Presents flits to the switch through a 2-entry skid buffer.
//  - fifo_ready is a register output, so there is no combinational path from FIFO output back to FIFO input.

---
 rtl/lisnoc_router_input_route_vc_pkg.sv | 9 +
 rtl/lisnoc_router_input_route_vc_if.sv | 22 ++
 rtl/lisnoc_router_input_route_lane.sv | 72 +++++++
 rtl/lisnoc_router_input_route_vc.sv | 46 ++++
 tb/tb_lisnoc_router_input_route_vc.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lisnoc_router_input_route_vc_pkg.sv
// lisnoc_router_input_route_vc_pkg: flit type codes (same values as lisnoc_def.vh) and lane route states.
// LISNOC_ROUTE_ERR_EN: when defined, unroutable or orphaned flits are popped and dropped with a route_error pulse.
package lisnoc_router_input_route_vc_pkg;
  localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_e;
endpackage

// File: rtl/lisnoc_router_input_route_vc_if.sv
// lisnoc_router_input_route_vc_if: FIFO-side and switch-side buses of the multi-VC input route stage.
interface lisnoc_router_input_route_vc_if #(
  parameter int vchannels = 1,
  parameter int flit_width = 34,
  parameter int directions = 5
);
  logic [vchannels*flit_width-1:0] fifo_flit;
  logic [vchannels-1:0] fifo_valid;
  logic [vchannels-1:0] fifo_ready;
  logic [vchannels*directions-1:0] switch_request;
  logic [vchannels*flit_width-1:0] switch_flit;
  logic [vchannels*directions-1:0] switch_read;
  logic [vchannels-1:0] route_error;
  modport master(
    output fifo_flit, fifo_valid, switch_read,
    input fifo_ready, switch_request, switch_flit, route_error
  );
  modport slave(
    input fifo_flit, fifo_valid, switch_read,
    output fifo_ready, switch_request, switch_flit, route_error
  );
endinterface

// File: rtl/lisnoc_router_input_route_lane.sv
// lisnoc_router_input_route_lane: one VC's route state machine, destination lookup and 2-entry skid buffer.
// LISNOC_ROUTE_ERR_EN enables dropping of unroutable/orphaned flits with a route_error pulse.
module lisnoc_router_input_route_lane
  import lisnoc_router_input_route_vc_pkg::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width = 5,
  parameter int num_dests = 1,
  parameter int directions = 5,
  parameter logic [directions*num_dests-1:0] lookup = '0,
  localparam int flit_width = flit_data_width + flit_type_width
) (
  input  logic clk,
  input  logic rst,
  input  logic [flit_width-1:0] fifo_flit,
  input  logic fifo_valid,
  output logic fifo_ready,
  output logic [directions-1:0] switch_request,
  output logic [flit_width-1:0] switch_flit,
  input  logic [directions-1:0] switch_read,
  output logic route_error
);
  state_e state;
  logic [directions-1:0] route_q, lk, in_req, skid_req;
  logic [flit_width-1:0] skid_flit;
  logic [flit_type_width-1:0] ftype;
  logic [ph_dest_width-1:0] dest;
  logic accept, hs, oor, drop, out_free, skid_v;
  assign ftype = fifo_flit[flit_width-1 -: flit_type_width];
  assign dest = fifo_flit[flit_data_width-1 -: ph_dest_width];
  assign accept = fifo_valid & fifo_ready;
  assign hs = ftype == FLIT_TYPE_HEADER || ftype == FLIT_TYPE_SINGLE;
  assign oor = int'(dest) >= num_dests;
  // dest0 sits in the MSBs; unknown destinations fall back to entry 0
  assign lk = lookup[(num_dests - 1 - (oor ? 0 : int'(dest))) * directions +: directions];
`ifdef LISNOC_ROUTE_ERR_EN
  assign drop = hs ? oor : state != PKT;
  always_ff @(posedge clk or posedge rst)
    if (rst) route_error <= 1'b0;
    else route_error <= accept & (hs ? oor : state == IDLE);
`else
  assign drop = 1'b0;
  assign route_error = 1'b0;
`endif
  // a zero request marks an empty entry, so dropped flits never occupy the buffer
  assign in_req = accept && !drop ? (hs ? lk : route_q) : '0;
  assign skid_v = |skid_req;
  assign out_free = !(|switch_request) || |(switch_read & switch_request);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      route_q <= '0;
      switch_request <= '0;
      switch_flit <= '0;
      skid_req <= '0;
      skid_flit <= '0;
      fifo_ready <= 1'b1;
    end else begin
      if (out_free) begin
        switch_request <= skid_v ? skid_req : in_req;
        switch_flit <= skid_v ? skid_flit : fifo_flit;
      end
      skid_req <= out_free ? '0 : skid_v ? skid_req : in_req;
      if (!skid_v) skid_flit <= fifo_flit;
      fifo_ready <= out_free || !(skid_v || |in_req);
      if (accept) begin
        state <= ftype == FLIT_TYPE_HEADER ? (drop ? DROP : PKT) : ftype == FLIT_TYPE_PAYLOAD ? state : IDLE;
        if (ftype == FLIT_TYPE_HEADER && !drop) route_q <= lk;
      end
    end
endmodule

// File: rtl/lisnoc_router_input_route_vc.sv
// lisnoc_router_input_route_vc: multi-VC router input routing stage, one independent lane per virtual channel.
// LISNOC_ROUTE_ERR_EN enables per-lane drop of unroutable packets with route_error pulses.
module lisnoc_router_input_route_vc
  import lisnoc_router_input_route_vc_pkg::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width = 5,
  parameter int num_dests = 1,
  parameter int directions = 5,
  parameter int vchannels = 1,
  parameter logic [directions*num_dests-1:0] lookup = '0
) (
  input logic clk,
  input logic rst,
  lisnoc_router_input_route_vc_if.slave bus
);
  localparam int fw = flit_data_width + flit_type_width;
  logic [vchannels*directions-1:0] req;
  logic [vchannels*fw-1:0] flit;
  logic [vchannels-1:0] ready, err;
  for (genvar v = 0; v < vchannels; v++) begin : g_lane
    lisnoc_router_input_route_lane #(
      .flit_data_width(flit_data_width),
      .flit_type_width(flit_type_width),
      .ph_dest_width(ph_dest_width),
      .num_dests(num_dests),
      .directions(directions),
      .lookup(lookup)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .fifo_flit(bus.fifo_flit[v*fw +: fw]),
      .fifo_valid(bus.fifo_valid[v]),
      .fifo_ready(ready[v]),
      .switch_request(req[v*directions +: directions]),
      .switch_flit(flit[v*fw +: fw]),
      .switch_read(bus.switch_read[v*directions +: directions]),
      .route_error(err[v])
    );
  end
  assign bus.fifo_ready = ready;
  assign bus.switch_request = req;
  assign bus.switch_flit = flit;
  assign bus.route_error = err;
endmodule

// File: tb/tb_lisnoc_router_input_route_vc.sv
// tb_lisnoc_router_input_route_vc: directed scenarios plus randomized traffic against a queue-based lane model.
module tb_lisnoc_router_input_route_vc;
  localparam logic [1:0] PAY = 2'b00, HDR = 2'b01, LST = 2'b10, SGL = 2'b11;
`ifdef LISNOC_ROUTE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [4:0] LUT [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  int m_cnt [2];
  int m_mode [2];
  logic [4:0] m_route [2];
  logic m_rdy [2], m_err [2], m_acc [2];
  logic [4:0] m_req [2][2];
  logic [33:0] m_flit [2][2];
  bit g_pkt [2];

  lisnoc_router_input_route_vc_if #(.vchannels(2), .flit_width(34), .directions(5)) bus();
  lisnoc_router_input_route_vc #(
    .num_dests(4), .directions(5), .vchannels(2),
    .lookup({5'b00001, 5'b00010, 5'b00100, 5'b01000})
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [33:0] mk(input logic [1:0] t, input logic [4:0] d, input logic [26:0] p);
    return {t, d, p};
  endfunction
  function automatic logic [4:0] req_of(input int v);
    return bus.switch_request[v*5 +: 5];
  endfunction
  function automatic logic [33:0] flit_of(input int v);
    return bus.switch_flit[v*34 +: 34];
  endfunction

  task automatic set_lane(input int v, input logic valid, input logic [33:0] f, input logic [4:0] rd);
    bus.fifo_valid[v] = valid;
    bus.fifo_flit[v*34 +: 34] = f;
    bus.switch_read[v*5 +: 5] = rd;
  endtask

  // occupancy-count model: entries kept in arrival order, route decided from flit type and packet mode
  task automatic model_update();
    for (int v = 0; v < 2; v++) begin
      logic [33:0] f;
      logic [4:0] d, r;
      logic [1:0] t;
      logic drop;
      f = bus.fifo_flit[v*34 +: 34];
      t = f[33:32];
      d = f[31:27];
      if (rst) begin
        m_cnt[v] = 0; m_mode[v] = 0; m_route[v] = '0;
        m_rdy[v] = 1'b1; m_err[v] = 1'b0; m_acc[v] = 1'b0;
      end else begin
        m_acc[v] = bus.fifo_valid[v] && m_rdy[v];
        if (m_cnt[v] > 0 && (bus.switch_read[v*5 +: 5] & m_req[v][0]) != 0) begin
          m_req[v][0] = m_req[v][1];
          m_flit[v][0] = m_flit[v][1];
          m_cnt[v]--;
        end
        drop = 1'b0;
        m_err[v] = 1'b0;
        r = m_route[v];
        if (m_acc[v]) begin
          if (t == HDR || t == SGL) begin
            if (ERR_EN && d >= 4) begin
              drop = 1'b1; m_err[v] = 1'b1; m_mode[v] = (t == HDR) ? 2 : 0;
            end else begin
              r = LUT[d < 4 ? d[1:0] : 2'd0];
              m_mode[v] = (t == HDR) ? 1 : 0;
              if (t == HDR) m_route[v] = r;
            end
          end else begin
            if (ERR_EN && m_mode[v] != 1) begin
              drop = 1'b1; m_err[v] = (m_mode[v] == 0);
            end
            if (t == LST) m_mode[v] = 0;
          end
          if (!drop && r != 0) begin
            m_req[v][m_cnt[v]] = r;
            m_flit[v][m_cnt[v]] = f;
            m_cnt[v]++;
          end
        end
        m_rdy[v] = m_cnt[v] < 2;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_lane(0, 1'b0, '0, '0);
    set_lane(1, 1'b0, '0, '0);
    cycle();
    cycle();
    n_vec++; if (bus.fifo_ready !== 2'b11) begin n_bad++; $display("FAIL reset_ready got %b want 11", bus.fifo_ready); end
    n_vec++; if (bus.switch_request !== 10'b0) begin n_bad++; $display("FAIL reset_request got %b want 0", bus.switch_request); end
    n_vec++; if (bus.switch_flit !== 68'b0) begin n_bad++; $display("FAIL reset_flit got %h want 0", bus.switch_flit); end
    n_vec++; if (bus.route_error !== 2'b00) begin n_bad++; $display("FAIL reset_error got %b want 00", bus.route_error); end
    rst = 1'b0;
  endtask

  task automatic test_packet();
    logic [33:0] f [3];
    f[0] = mk(HDR, 5'd2, 27'd1); f[1] = mk(PAY, 5'd9, 27'd2); f[2] = mk(LST, 5'd9, 27'd3);
    n_vec++; if (req_of(0) !== 5'b0) begin n_bad++; $display("FAIL pkt_idle_req got %b want 00000", req_of(0)); end
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1'b1, f[k], 5'b11111);
      cycle();
      n_vec++; if (req_of(0) !== 5'b00100) begin n_bad++; $display("FAIL pkt_req%0d got %b want 00100", k, req_of(0)); end
      n_vec++; if (flit_of(0) !== f[k]) begin n_bad++; $display("FAIL pkt_flit%0d got %h want %h", k, flit_of(0), f[k]); end
      n_vec++; if (bus.fifo_ready[0] !== 1'b1) begin n_bad++; $display("FAIL pkt_ready%0d got %b want 1", k, bus.fifo_ready[0]); end
    end
    set_lane(0, 1'b0, '0, 5'b11111);
    cycle();
    n_vec++; if (req_of(0) !== 5'b0) begin n_bad++; $display("FAIL pkt_drain got %b want 00000", req_of(0)); end
  endtask

  task automatic test_stall();
    logic [33:0] s [3];
    logic [33:0] want_f [7];
    logic want_r [7];
    for (int k = 0; k < 3; k++) s[k] = mk(SGL, 5'd1, 27'(10 + k));
    want_f = '{s[0], s[0], s[0], s[0], s[1], s[2], s[2]};
    want_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      set_lane(0, 1'b1, s[k < 2 ? k : 2], k < 4 ? 5'b00000 : 5'b00010);
      cycle();
      n_vec++; if (req_of(0) !== 5'b00010) begin n_bad++; $display("FAIL stall_req%0d got %b want 00010", k, req_of(0)); end
      n_vec++; if (flit_of(0) !== want_f[k]) begin n_bad++; $display("FAIL stall_flit%0d got %h want %h", k, flit_of(0), want_f[k]); end
      n_vec++; if (bus.fifo_ready[0] !== want_r[k]) begin n_bad++; $display("FAIL stall_ready%0d got %b want %b", k, bus.fifo_ready[0], want_r[k]); end
    end
    set_lane(0, 1'b0, '0, 5'b00010);
    cycle();
    n_vec++; if (req_of(0) !== 5'b0) begin n_bad++; $display("FAIL stall_drain got %b want 00000", req_of(0)); end
  endtask

  task automatic test_concurrent();
    logic [33:0] f0 [4];
    logic [33:0] f1 [3];
    f0 = '{mk(HDR, 5'd0, 27'd20), mk(PAY, 5'd1, 27'd21), mk(PAY, 5'd2, 27'd22), mk(LST, 5'd3, 27'd23)};
    f1 = '{mk(HDR, 5'd3, 27'd30), mk(PAY, 5'd0, 27'd31), mk(LST, 5'd0, 27'd32)};
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 1'b1, f0[k], 5'b11111);
      set_lane(1, 1'b1, f1[k > 2 ? 2 : k], 5'b00000);
      cycle();
      n_vec++; if (req_of(0) !== 5'b00001) begin n_bad++; $display("FAIL conc_req0_%0d got %b want 00001", k, req_of(0)); end
      n_vec++; if (flit_of(0) !== f0[k]) begin n_bad++; $display("FAIL conc_flit0_%0d got %h want %h", k, flit_of(0), f0[k]); end
      n_vec++; if (bus.fifo_ready[0] !== 1'b1) begin n_bad++; $display("FAIL conc_ready0_%0d got %b want 1", k, bus.fifo_ready[0]); end
      n_vec++; if (req_of(1) !== 5'b01000) begin n_bad++; $display("FAIL conc_req1_%0d got %b want 01000", k, req_of(1)); end
      n_vec++; if (flit_of(1) !== f1[0]) begin n_bad++; $display("FAIL conc_flit1_%0d got %h want %h", k, flit_of(1), f1[0]); end
    end
    set_lane(0, 1'b0, '0, 5'b11111);
    cycle();
    n_vec++; if (req_of(0) !== 5'b0) begin n_bad++; $display("FAIL conc_drain0 got %b want 00000", req_of(0)); end
    n_vec++; if (bus.fifo_ready[1] !== 1'b0) begin n_bad++; $display("FAIL conc_ready1 got %b want 0", bus.fifo_ready[1]); end
  endtask

  task automatic test_reset_mid();
    logic [33:0] h, p;
    h = mk(HDR, 5'd2, 27'd40);
    p = mk(PAY, 5'd3, 27'd41);
    rst = 1'b1;
    #1;
    n_vec++; if (bus.switch_request !== 10'b0) begin n_bad++; $display("FAIL rstmid_req got %b want 0", bus.switch_request); end
    n_vec++; if (bus.fifo_ready !== 2'b11) begin n_bad++; $display("FAIL rstmid_ready got %b want 11", bus.fifo_ready); end
    set_lane(0, 1'b0, '0, '0);
    set_lane(1, 1'b0, '0, '0);
    cycle();
    n_vec++; if (bus.switch_request !== 10'b0) begin n_bad++; $display("FAIL rstmid_req2 got %b want 0", bus.switch_request); end
    n_vec++; if (bus.fifo_ready !== 2'b11) begin n_bad++; $display("FAIL rstmid_ready2 got %b want 11", bus.fifo_ready); end
    rst = 1'b0;
    set_lane(1, 1'b1, h, 5'b11111);
    cycle();
    n_vec++; if (req_of(1) !== 5'b00100) begin n_bad++; $display("FAIL rstmid_hdr got %b want 00100", req_of(1)); end
    n_vec++; if (flit_of(1) !== h) begin n_bad++; $display("FAIL rstmid_hflit got %h want %h", flit_of(1), h); end
    set_lane(1, 1'b1, p, 5'b11111);
    cycle();
    n_vec++; if (req_of(1) !== 5'b00100) begin n_bad++; $display("FAIL rstmid_pay got %b want 00100", req_of(1)); end
    set_lane(1, 1'b0, '0, 5'b11111);
    cycle();
    n_vec++; if (req_of(1) !== 5'b0) begin n_bad++; $display("FAIL rstmid_drain got %b want 00000", req_of(1)); end
  endtask

  task automatic test_bad_dest();
    logic [33:0] f [3];
    int errs = 0;
    f = '{mk(HDR, 5'd7, 27'd50), mk(PAY, 5'd0, 27'd51), mk(LST, 5'd0, 27'd52)};
    for (int k = 0; k < 4; k++) begin
      set_lane(0, k < 3, k < 3 ? f[k < 3 ? k : 0] : '0, 5'b11111);
      cycle();
      errs += int'(bus.route_error[0]);
      n_vec++; if (bus.fifo_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bad_ready%0d got %b want 1", k, bus.fifo_ready[0]); end
`ifdef LISNOC_ROUTE_ERR_EN
      n_vec++; if (req_of(0) !== 5'b0) begin n_bad++; $display("FAIL bad_req%0d got %b want 00000", k, req_of(0)); end
`else
      if (k < 3) begin
        n_vec++; if (req_of(0) !== 5'b00001) begin n_bad++; $display("FAIL bad_req%0d got %b want 00001", k, req_of(0)); end
        n_vec++; if (flit_of(0) !== f[k]) begin n_bad++; $display("FAIL bad_flit%0d got %h want %h", k, flit_of(0), f[k]); end
      end
`endif
    end
`ifdef LISNOC_ROUTE_ERR_EN
    n_vec++; if (errs != 1) begin n_bad++; $display("FAIL bad_err_cycles got %0d want 1", errs); end
`else
    n_vec++; if (errs != 0) begin n_bad++; $display("FAIL bad_err_cycles got %0d want 0", errs); end
`endif
  endtask

  task automatic test_ignored_read();
    logic [33:0] s;
    s = mk(SGL, 5'd2, 27'd60);
    set_lane(0, 1'b1, s, 5'b10000);
    cycle();
    set_lane(0, 1'b0, '0, 5'b10000);
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (req_of(0) !== 5'b00100) begin n_bad++; $display("FAIL ign_req%0d got %b want 00100", k, req_of(0)); end
      n_vec++; if (flit_of(0) !== s) begin n_bad++; $display("FAIL ign_flit%0d got %h want %h", k, flit_of(0), s); end
      cycle();
    end
    bus.switch_read[4:0] = 5'b00100;
    cycle();
    n_vec++; if (req_of(0) !== 5'b0) begin n_bad++; $display("FAIL ign_consume got %b want 00000", req_of(0)); end
  endtask

  task automatic gen(input int v);
    int r;
    logic [1:0] t;
    logic [4:0] d;
    r = $urandom_range(0, 99);
    if (g_pkt[v]) t = r < 55 ? PAY : r < 90 ? LST : r < 95 ? HDR : SGL;
    else t = r < 45 ? HDR : r < 90 ? SGL : r < 95 ? PAY : LST;
    g_pkt[v] = (t == HDR) || (t == PAY && g_pkt[v]);
    d = $urandom_range(0, 9) < 8 ? 5'($urandom_range(0, 3)) : 5'($urandom_range(4, 31));
    bus.fifo_flit[v*34 +: 34] = mk(t, d, 27'($urandom));
  endtask

  task automatic test_random();
    for (int v = 0; v < 2; v++) begin g_pkt[v] = 1'b0; gen(v); end
    for (int c = 0; c < 400; c++) begin
      for (int v = 0; v < 2; v++) begin
        int rr;
        rr = $urandom_range(0, 3);
        bus.fifo_valid[v] = $urandom_range(0, 3) != 0;
        bus.switch_read[v*5 +: 5] = rr == 0 ? 5'b0 : rr == 1 ? 5'($urandom) : 5'b11111;
      end
      cycle();
      for (int v = 0; v < 2; v++) begin
        logic [4:0] er;
        er = m_cnt[v] > 0 ? m_req[v][0] : 5'b0;
        n_vec++; if (bus.fifo_ready[v] !== m_rdy[v]) begin n_bad++; $display("FAIL rnd_ready c%0d lane%0d got %b want %b", c, v, bus.fifo_ready[v], m_rdy[v]); end
        n_vec++; if (req_of(v) !== er) begin n_bad++; $display("FAIL rnd_req c%0d lane%0d got %b want %b", c, v, req_of(v), er); end
        if (m_cnt[v] > 0) begin
          n_vec++; if (flit_of(v) !== m_flit[v][0]) begin n_bad++; $display("FAIL rnd_flit c%0d lane%0d got %h want %h", c, v, flit_of(v), m_flit[v][0]); end
        end
        n_vec++; if (bus.route_error[v] !== m_err[v]) begin n_bad++; $display("FAIL rnd_err c%0d lane%0d got %b want %b", c, v, bus.route_error[v], m_err[v]); end
        if (m_acc[v]) gen(v);
      end
    end
    set_lane(0, 1'b0, '0, '0);
    set_lane(1, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_packet();
    test_stall();
    test_concurrent();
    test_reset_mid();
    test_bad_dest();
    test_ignored_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
